// File: rtl/ifu_pkg.sv
// Shared types and constants for the instruction fetch unit.
// Optional misaligned-target check is enabled with IFU_MISALIGN_CHK_EN.
package ifu_pkg;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      REQ  = 2'd1,
      WAIT = 2'd2,
      OUT  = 2'd3
   } fetch_state_t;

   typedef struct packed {
      logic        valid;
      logic [63:0] addr;
   } ibus_req_t;

   typedef struct packed {
      logic        addr_ok;
      logic        data_ok;
      logic [31:0] data;
   } ibus_resp_t;

   localparam logic [63:0] RESET_PC_DEFAULT = 64'h0000_0000_8000_0000;
   localparam logic [31:0] NOP_INSTR        = 32'h0000_0013;

   function automatic logic is_misaligned(input logic [63:0] addr);
      return (addr[1:0] != 2'b00);
   endfunction

endpackage

// File: rtl/ifu_fetch_pc_reg.sv
// Architectural PC register: reset / redirect / sequential step / hold,
// plus the condition that makes an in-flight response stale.
module ifu_pc_reg
   import ifu_pkg::*;
#(
   parameter logic [63:0] RESET_PC = RESET_PC_DEFAULT,
   parameter int unsigned PC_STEP  = 32'd4
) (
   input  logic        clk,
   input  logic        rst_n,
   input  logic        redirect_valid,
   input  logic [63:0] redirect_pc,
   input  logic        advance,
   input  logic        in_flight,
   output logic [63:0] pc_q,
   output logic [63:0] pc_next,
   output logic        drop_set
);

   logic [63:0] pc_r;
   logic [63:0] pc_nx_s;

   // next-PC select; redirect outranks a same-cycle accept
   always_comb begin
      pc_nx_s = pc_r;
      if (redirect_valid) begin
         pc_nx_s = redirect_pc;
      end else if (advance) begin
         pc_nx_s = pc_r + 64'(PC_STEP);
      end else begin
         pc_nx_s = pc_r;
      end
   end

   // PC register
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         pc_r <= RESET_PC;
      end else begin
         pc_r <= pc_nx_s;
      end
   end

   assign pc_q     = pc_r;
   assign pc_next  = pc_nx_s;
   assign drop_set = redirect_valid & in_flight;

endmodule

// File: rtl/ifu_fetch.sv
// Instruction fetch unit: one outstanding bus request, valid/ready to decode.
// Define IFU_MISALIGN_CHK_EN to turn misaligned targets into a flagged NOP.
module ifu_fetch
   import ifu_pkg::*;
#(
   parameter logic [63:0] RESET_PC = RESET_PC_DEFAULT,
   parameter int unsigned PC_STEP  = 32'd4
) (
   input  logic        clk,
   input  logic        rst_n,
   output logic        ireq_valid,
   output logic [63:0] ireq_addr,
   input  logic        iresp_addr_ok,
   input  logic        iresp_data_ok,
   input  logic [31:0] iresp_data,
   input  logic        redirect_valid,
   input  logic [63:0] redirect_pc,
   output logic        ifu_valid,
   input  logic        ifu_ready,
   output logic [31:0] instr,
   output logic [63:0] pc,
   output logic        fetch_misalign
);

   fetch_state_t state_r, state_nx_s;
   ibus_req_t    req_r, req_nx_s;
   ibus_resp_t   resp_s;
   logic         ifu_valid_r, ifu_valid_nx_s;
   logic [31:0]  instr_r, instr_nx_s;
   logic [63:0]  pc_out_r, pc_out_nx_s;
   logic         drop_r, drop_nx_s;
   logic         misalign_r, misalign_nx_s;
   logic [63:0]  pc_q_s, pc_next_s;
   logic         drop_set_s, advance_s, in_flight_s, issue_s, misalign_hit_s;

   assign resp_s      = '{addr_ok: iresp_addr_ok, data_ok: iresp_data_ok, data: iresp_data};
   assign advance_s   = (state_r == OUT) & ifu_ready;
   assign in_flight_s = ((state_r == REQ) & req_r.valid) | (state_r == WAIT);

`ifdef IFU_MISALIGN_CHK_EN
   assign misalign_hit_s = (state_r == REQ) & is_misaligned(req_r.addr);
`else
   assign misalign_hit_s = 1'b0;
`endif

   ifu_pc_reg #(
      .RESET_PC (RESET_PC),
      .PC_STEP  (PC_STEP)
   ) u_pc_reg (
      .clk            (clk),
      .rst_n          (rst_n),
      .redirect_valid (redirect_valid),
      .redirect_pc    (redirect_pc),
      .advance        (advance_s),
      .in_flight      (in_flight_s),
      .pc_q           (pc_q_s),
      .pc_next        (pc_next_s),
      .drop_set       (drop_set_s)
   );

   // next state and next values of every registered output
   always_comb begin
      state_nx_s     = state_r;
      req_nx_s       = req_r;
      ifu_valid_nx_s = ifu_valid_r;
      instr_nx_s     = instr_r;
      pc_out_nx_s    = pc_out_r;
      drop_nx_s      = drop_r;
      misalign_nx_s  = misalign_r;
      issue_s        = 1'b0;
      case (state_r)
         IDLE: begin
            state_nx_s = REQ;
            issue_s    = 1'b1;
         end
         REQ: begin
            if (misalign_hit_s) begin
               if (redirect_valid) begin
                  issue_s = 1'b1;
               end else begin
                  state_nx_s     = OUT;
                  ifu_valid_nx_s = 1'b1;
                  instr_nx_s     = NOP_INSTR;
                  pc_out_nx_s    = pc_q_s;
                  misalign_nx_s  = 1'b1;
               end
            end else if (resp_s.addr_ok) begin
               if (resp_s.data_ok && (drop_r || drop_set_s)) begin
                  drop_nx_s = 1'b0;
                  issue_s   = 1'b1;
               end else if (resp_s.data_ok) begin
                  state_nx_s     = OUT;
                  ifu_valid_nx_s = 1'b1;
                  instr_nx_s     = resp_s.data;
                  pc_out_nx_s    = pc_q_s;
                  misalign_nx_s  = 1'b0;
               end else begin
                  state_nx_s = WAIT;
                  drop_nx_s  = drop_r | drop_set_s;
               end
            end else begin
               // address must stay put until accepted, so a redirect only marks the reply stale
               drop_nx_s = drop_r | drop_set_s;
            end
         end
         WAIT: begin
            if (resp_s.data_ok && (drop_r || drop_set_s)) begin
               state_nx_s = REQ;
               drop_nx_s  = 1'b0;
               issue_s    = 1'b1;
            end else if (resp_s.data_ok) begin
               state_nx_s     = OUT;
               ifu_valid_nx_s = 1'b1;
               instr_nx_s     = resp_s.data;
               pc_out_nx_s    = pc_q_s;
               misalign_nx_s  = 1'b0;
            end else begin
               drop_nx_s = drop_r | drop_set_s;
            end
         end
         OUT: begin
            if (redirect_valid || ifu_ready) begin
               state_nx_s     = REQ;
               ifu_valid_nx_s = 1'b0;
               misalign_nx_s  = 1'b0;
               issue_s        = 1'b1;
            end else begin
               state_nx_s = OUT;
            end
         end
         default: begin
            state_nx_s = IDLE;
         end
      endcase

      if (issue_s) begin
         req_nx_s.addr = pc_next_s;
`ifdef IFU_MISALIGN_CHK_EN
         req_nx_s.valid = !is_misaligned(pc_next_s);
`else
         req_nx_s.valid = 1'b1;
`endif
      end else if (state_nx_s != REQ) begin
         req_nx_s.valid = 1'b0;
      end else begin
         req_nx_s.valid = req_r.valid;
      end
   end

   // state and output registers
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_r     <= IDLE;
         req_r.valid <= 1'b0;
         req_r.addr  <= RESET_PC;
         ifu_valid_r <= 1'b0;
         instr_r     <= 32'h0000_0000;
         pc_out_r    <= RESET_PC;
         drop_r      <= 1'b0;
         misalign_r  <= 1'b0;
      end else begin
         state_r     <= state_nx_s;
         req_r       <= req_nx_s;
         ifu_valid_r <= ifu_valid_nx_s;
         instr_r     <= instr_nx_s;
         pc_out_r    <= pc_out_nx_s;
         drop_r      <= drop_nx_s;
         misalign_r  <= misalign_nx_s;
      end
   end

   assign ireq_valid     = req_r.valid;
   assign ireq_addr      = req_r.addr;
   assign ifu_valid      = ifu_valid_r;
   assign instr          = instr_r;
   assign pc             = pc_out_r;
   assign fetch_misalign = misalign_r;

endmodule

// File: tb/tb_ifu_fetch.sv
// Self-checking bench for ifu_fetch: directed scenarios then random bus
// latencies, decode back-pressure and redirects against a transaction-level PC model.
module tb_ifu_fetch;

   logic        clk = 1'b0;
   logic        rst_n = 1'b0;
   logic        ireq_valid;
   logic [63:0] ireq_addr;
   logic        iresp_addr_ok = 1'b0;
   logic        iresp_data_ok = 1'b0;
   logic [31:0] iresp_data = 32'h0;
   logic        redirect_valid = 1'b0;
   logic [63:0] redirect_pc = 64'h0;
   logic        ifu_valid;
   logic        ifu_ready = 1'b0;
   logic [31:0] instr;
   logic [63:0] pc;
   logic        fetch_misalign;

   int checks = 0;
   int failures = 0;
   int accepts = 0;

   // stimulus knobs and memory/model state
   logic        ready_v = 1'b0, redir_v = 1'b0, rand_lat = 1'b0;
   logic [63:0] redir_pc_v = 64'h0;
   int          addr_lat = 0, data_lat = 0, addr_wait = 0, data_wait = 0;
   logic        mem_busy = 1'b0;
   logic [63:0] mem_addr = 64'h0;
   logic [63:0] model_pc = 64'h0000_0000_8000_0000;
   logic        prev_req_hold = 1'b0, prev_out_hold = 1'b0, prev_redir_out = 1'b0;
   logic [63:0] prev_addr = 64'h0, prev_pc = 64'h0, saved_pc;
   logic [31:0] prev_instr = 32'h0, saved_instr;

   ifu_fetch dut (
      .clk            (clk),
      .rst_n          (rst_n),
      .ireq_valid     (ireq_valid),
      .ireq_addr      (ireq_addr),
      .iresp_addr_ok  (iresp_addr_ok),
      .iresp_data_ok  (iresp_data_ok),
      .iresp_data     (iresp_data),
      .redirect_valid (redirect_valid),
      .redirect_pc    (redirect_pc),
      .ifu_valid      (ifu_valid),
      .ifu_ready      (ifu_ready),
      .instr          (instr),
      .pc             (pc),
      .fetch_misalign (fetch_misalign)
   );

   always #5 clk = ~clk;

   function automatic logic [31:0] mem_word(input logic [63:0] a);
      logic [31:0] h;
      if (a == 64'h0000_0000_8000_0000) return 32'h0000_0013;
      h = a[31:0] ^ a[63:32];
      return (h * 32'h9E37_79B9) ^ 32'h0000_0A03;
   endfunction

   function automatic logic [31:0] exp_instr(input logic [63:0] a);
`ifdef IFU_MISALIGN_CHK_EN
      if (a[1:0] != 2'b00) return 32'h0000_0013;
`endif
      return mem_word(a);
   endfunction

   task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      checks++;
      assert (obs === exp) else begin
         failures++;
         $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
      end
   endtask

   // one clock: observe at negedge, check invariants, drive memory/decode/redirect
   task automatic cycle();
      logic acc;
      logic exp_mis;
      @(negedge clk);
      if (prev_req_hold) begin
         check("req_hold_valid", 64'(ireq_valid), 64'd1);
         check("req_hold_addr", ireq_addr, prev_addr);
      end
      if (prev_out_hold) begin
         check("out_hold_valid", 64'(ifu_valid), 64'd1);
         check("out_hold_instr", 64'(instr), 64'(prev_instr));
         check("out_hold_pc", pc, prev_pc);
      end
      if (prev_redir_out) check("redirect_kills_valid", 64'(ifu_valid), 64'd0);
      if (ifu_valid) check("no_req_in_out", 64'(ireq_valid), 64'd0);
      if (mem_busy) check("one_outstanding", 64'(ireq_valid), 64'd0);
`ifdef IFU_MISALIGN_CHK_EN
      exp_mis = ifu_valid && (pc[1:0] != 2'b00);
`else
      exp_mis = 1'b0;
`endif
      check("misalign_flag", 64'(fetch_misalign), 64'(exp_mis));

      iresp_addr_ok = 1'b0;
      iresp_data_ok = 1'b0;
      iresp_data    = 32'h0;
      if (mem_busy) begin
         data_wait++;
         if (data_wait >= data_lat) begin
            iresp_data_ok = 1'b1;
            iresp_data    = mem_word(mem_addr);
            mem_busy      = 1'b0;
            if (rand_lat) begin
               addr_lat = $urandom_range(0, 3);
               data_lat = $urandom_range(0, 3);
            end
         end
      end else if (ireq_valid) begin
         if (addr_wait >= addr_lat) begin
            iresp_addr_ok = 1'b1;
            addr_wait     = 0;
            mem_addr      = ireq_addr;
            if (data_lat == 0) begin
               iresp_data_ok = 1'b1;
               iresp_data    = mem_word(ireq_addr);
            end else begin
               mem_busy  = 1'b1;
               data_wait = 0;
            end
         end else begin
            addr_wait++;
         end
      end

      ifu_ready      = ready_v;
      redirect_valid = redir_v;
      redirect_pc    = redir_v ? redir_pc_v : 64'h0;
      acc = ifu_valid && ready_v;
      if (acc) begin
         accepts++;
         check("accept_pc", pc, model_pc);
         check("accept_instr", 64'(instr), 64'(exp_instr(model_pc)));
      end
      prev_req_hold  = ireq_valid && !iresp_addr_ok;
      prev_addr      = ireq_addr;
      prev_out_hold  = ifu_valid && !ready_v && !redir_v;
      prev_instr     = instr;
      prev_pc        = pc;
      prev_redir_out = ifu_valid && redir_v;
      if (redir_v) model_pc = redir_pc_v;
      else if (acc) model_pc = model_pc + 64'd4;
      redir_v = 1'b0;
   endtask

   task automatic wait_ireq(input string tag);
      int n;
      n = 0;
      do begin cycle(); n++; end while (!ireq_valid && n < 30);
      check(tag, 64'(ireq_valid), 64'd1);
   endtask

   task automatic wait_valid(input string tag);
      int n;
      n = 0;
      do begin cycle(); n++; end while (!ifu_valid && n < 30);
      check(tag, 64'(ifu_valid), 64'd1);
   endtask

   initial begin
      // reset values
      repeat (2) @(negedge clk);
      check("rst_ireq_valid", 64'(ireq_valid), 64'd0);
      check("rst_ireq_addr", ireq_addr, 64'h0000_0000_8000_0000);
      check("rst_ifu_valid", 64'(ifu_valid), 64'd0);
      check("rst_instr", 64'(instr), 64'd0);
      check("rst_pc", pc, 64'h0000_0000_8000_0000);
      check("rst_misalign", 64'(fetch_misalign), 64'd0);
      rst_n = 1'b1;

      // zero-wait fetch of the reset PC, accept, next sequential request
      wait_ireq("t1_req_timeout");
      check("t1_req_addr", ireq_addr, 64'h0000_0000_8000_0000);
      ready_v = 1'b1;
      cycle();
      check("t1_valid", 64'(ifu_valid), 64'd1);
      check("t1_instr", 64'(instr), 64'h13);
      check("t1_pc", pc, 64'h0000_0000_8000_0000);
      ready_v = 1'b0;
      cycle();
      check("t1_next_valid", 64'(ireq_valid), 64'd1);
      check("t1_next_addr", ireq_addr, 64'h0000_0000_8000_0004);

      // addr_ok after 3 waiting cycles, data_ok 2 cycles later
      addr_lat = 3; data_lat = 2; ready_v = 1'b1;
      cycle();
      ready_v = 1'b0;
      for (int i = 0; i < 4; i++) begin
         cycle();
         check("t2_req_valid", 64'(ireq_valid), 64'd1);
         check("t2_req_addr", ireq_addr, 64'h0000_0000_8000_0008);
         check("t2_addr_ok_timing", 64'(iresp_addr_ok), 64'(i == 3));
      end
      cycle();
      check("t2_no_data_yet", 64'(iresp_data_ok), 64'd0);
      cycle();
      check("t2_data_ok", 64'(iresp_data_ok), 64'd1);
      check("t2_not_valid_yet", 64'(ifu_valid), 64'd0);
      cycle();
      check("t2_valid_after_data", 64'(ifu_valid), 64'd1);
      check("t2_pc", pc, 64'h0000_0000_8000_0008);

      // decode stalls five cycles, accepts on the sixth
      saved_pc = pc; saved_instr = instr;
      for (int i = 0; i < 4; i++) begin
         cycle();
         check("t3_no_req", 64'(ireq_valid), 64'd0);
      end
      check("t3_pc_stable", pc, saved_pc);
      check("t3_instr_stable", 64'(instr), 64'(saved_instr));
      addr_lat = 0; data_lat = 3; ready_v = 1'b1;
      cycle();
      ready_v = 1'b0;
      cycle();
      check("t3_next_valid", 64'(ireq_valid), 64'd1);
      check("t3_next_addr", ireq_addr, 64'h0000_0000_8000_000C);

      // redirect while waiting for data: stale reply dropped
      redir_v = 1'b1; redir_pc_v = 64'h0000_0000_8000_1000;
      cycle();
      begin
         int n;
         n = 0;
         do begin
            cycle(); n++;
            check("t4_stale_not_shown", 64'(ifu_valid), 64'd0);
         end while (!ireq_valid && n < 20);
      end
      check("t4_req_valid", 64'(ireq_valid), 64'd1);
      check("t4_req_addr", ireq_addr, 64'h0000_0000_8000_1000);

      // redirect in the same cycle as accept
      wait_valid("t5_valid_timeout");
      check("t5_pc", pc, 64'h0000_0000_8000_1000);
      addr_lat = 0; data_lat = 0;
      ready_v = 1'b1; redir_v = 1'b1; redir_pc_v = 64'h0000_0000_8000_2000;
      cycle();
      ready_v = 1'b0;
      cycle();
      check("t5_req_valid", 64'(ireq_valid), 64'd1);
      check("t5_req_addr", ireq_addr, 64'h0000_0000_8000_2000);

      // misaligned redirect target
      wait_valid("t6_valid_timeout");
      ready_v = 1'b1; redir_v = 1'b1; redir_pc_v = 64'h0000_0000_8000_0002;
      cycle();
      ready_v = 1'b0;
      cycle();
`ifdef IFU_MISALIGN_CHK_EN
      check("t6_no_req", 64'(ireq_valid), 64'd0);
      cycle();
      check("t6_valid", 64'(ifu_valid), 64'd1);
      check("t6_instr_nop", 64'(instr), 64'h13);
      check("t6_flag", 64'(fetch_misalign), 64'd1);
      check("t6_pc", pc, 64'h0000_0000_8000_0002);
      ready_v = 1'b1; redir_v = 1'b1; redir_pc_v = 64'h0000_0000_8000_3000;
      cycle();
      ready_v = 1'b0;
`else
      check("t6_req_valid", 64'(ireq_valid), 64'd1);
      check("t6_req_addr", ireq_addr, 64'h0000_0000_8000_0002);
      wait_valid("t6_valid_timeout2");
      check("t6_pc", pc, 64'h0000_0000_8000_0002);
      check("t6_instr", 64'(instr), 64'(mem_word(64'h0000_0000_8000_0002)));
`endif

      // random latencies, back-pressure and redirects (including a wrapping target)
      rand_lat = 1'b1;
      accepts = 0;
      for (int i = 0; i < 600; i++) begin
         ready_v = ($urandom_range(0, 3) != 0);
         if ($urandom_range(0, 15) == 0) begin
            redir_v = 1'b1;
            if ($urandom_range(0, 3) == 0) redir_pc_v = 64'hFFFF_FFFF_FFFF_FFFC;
            else redir_pc_v = {32'h0, 32'h8000_0000 | ($urandom() & 32'h0000_FFFC)};
         end
         cycle();
      end
      check("random_progress", 64'(accepts > 50), 64'd1);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule

// File: doc/ifu_fetch.md
Name: ifu_fetch

Overview:
- Instruction fetch unit. Owns the architectural PC and issues 32-bit fetch requests on the instruction bus.
- Presents each returned instruction to the decode stage with a valid/ready handshake.
- Decode consumes `instr`/`ifu_valid`; execute/branch logic steers the PC through the redirect port.
- Upstream producer for the decode stage's `instr`/valid inputs.

Parameters:
- RESET_PC, 64'h8000_0000, PC loaded on reset.
- PC_STEP, 4, sequential PC increment in bytes.

Ports:
- clk  in  1  clock, rising edge.
- rst_n  in  1  asynchronous reset, active low.
- ireq_valid  out  1  fetch request valid.
- ireq_addr  out  64  fetch address.
- iresp_addr_ok  in  1  bus accepted the request address.
- iresp_data_ok  in  1  read data valid.
- iresp_data  in  32  instruction word.
- redirect_valid  in  1  PC redirect (branch/jump), one-cycle pulse.
- redirect_pc  in  64  redirect target.
- ifu_valid  out  1  `instr`/`pc` valid to decode.
- ifu_ready  in  1  decode accepts this cycle (decode finish).
- instr  out  32  fetched instruction.
- pc  out  64  address of `instr`.
- fetch_misalign  out  1  misaligned target flag (optional feature only; tie 0 otherwise).

Behaviour:
- Reset (rst_n=0, async):
  - state=IDLE; pc_q=RESET_PC.
  - ireq_valid=0, ireq_addr=RESET_PC, ifu_valid=0, instr=0, pc=RESET_PC, drop=0, fetch_misalign=0.
- States:
  - IDLE: next cycle go to REQ.
  - REQ: ireq_valid=1, ireq_addr=pc_q, held stable until iresp_addr_ok. On addr_ok go to WAIT. If iresp_data_ok is also high that cycle, capture data and go to OUT (or REQ when drop applies).
  - WAIT: ireq_valid=0. On data_ok with drop=0: instr<=iresp_data, pc<=pc_q, go to OUT. On data_ok with drop=1: discard the data, clear drop, go to REQ.
  - OUT: ifu_valid=1; instr and pc held stable until ifu_valid&ifu_ready. On accept: pc_q<=pc_q+PC_STEP (64-bit wrap), go to REQ.
- Redirect, any state, highest priority for pc_q: pc_q<=redirect_pc.
  - IDLE: go to REQ with the new pc_q.
  - REQ before addr_ok: ireq_addr must not change (bus rule). Set drop=1; after addr_ok the stale response is discarded, then REQ re-issues with redirect_pc.
  - REQ on the addr_ok cycle: set drop=1. If data_ok is in the same cycle, discard and go to REQ.
  - WAIT: set drop=1.
  - OUT: ifu_valid falls next cycle; held instr discarded; go to REQ.
  - Redirect and accept in the same cycle: redirect wins; pc_q=redirect_pc, not +PC_STEP.
  - Back-to-back redirects: the last one wins; drop stays 1 until one response is discarded.
- Latency: with zero-wait memory (addr_ok and data_ok in the same cycle as the request), ifu_valid rises 1 cycle after REQ entry. Steady-state throughput is 1 instruction per 2 cycles (REQ, OUT).
- Exactly one outstanding request at a time. No request is issued while in OUT.

Optional Feature:
- Macro: IFU_MISALIGN_CHK_EN.
- Defined:
  - On entry to REQ with pc_q[1:0]!=0, no request is issued.
  - Go to OUT with instr=32'h0000_0013 (NOP), fetch_misalign=1, pc=pc_q.
  - fetch_misalign clears on accept or redirect.
- Undefined: no check; ireq_addr is driven unaligned; fetch_misalign tied 0.

Decomposition:
- Shared package ifu_pkg:
  - fetch_state_t enum {IDLE, REQ, WAIT, OUT}.
  - ibus_req_t struct {valid, addr[63:0]}.
  - ibus_resp_t struct {addr_ok, data_ok, data[31:0]}.
  - Constants RESET_PC_DEFAULT and NOP_INSTR=32'h0000_0013.
- One sub-module, ifu_pc_reg: holds pc_q, selects reset / redirect / +PC_STEP / hold, and reports the drop condition.
- The FSM and output registers stay in ifu_fetch.

Test Plan:
- Reset then zero-wait memory returning 32'h00000013 at 0x80000000 -> ireq_addr=0x80000000; ifu_valid=1, instr=0x13, pc=0x80000000; after accept, the next ireq_addr=0x80000004.
- addr_ok delayed 3 cycles, data_ok 2 cycles later -> ireq_valid and ireq_addr stable for all 3 cycles; ifu_valid rises 1 cycle after data_ok.
- Decode holds ifu_ready=0 for 5 cycles -> instr/pc stable; no new ireq_valid; accept on cycle 6 -> fetch of pc+4.
- Redirect to 0x80001000 while in WAIT -> stale data discarded with ifu_valid never asserted for it; next ireq_addr=0x80001000.
- Redirect 0x80002000 in the same cycle as accept in OUT -> next ireq_addr=0x80002000, not pc+4.
- With IFU_MISALIGN_CHK_EN, redirect to 0x80000002 -> no ireq_valid; ifu_valid=1, instr=0x13, fetch_misalign=1, pc=0x80000002.
